// File: rtl/register_file_pkg.sv
// Shared processor definitions for the register file: default geometry and
// the architectural zero-register address.
package register_file_pkg;

   localparam int RF_DATA_WIDTH = 8;
   localparam int RF_ADDR_WIDTH = 4;

   // Address of the hardwired-zero register.
   localparam int unsigned REG_ZERO = 0;

endpackage : register_file_pkg

// File: rtl/register_file_read_mux.sv
// One combinational read port: selects a register from the packed storage
// image and forces the zero register to read as 0.
module regfile_read_mux
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
   input  logic [ADDR_WIDTH-1:0]                      read_addr,
   output logic [DATA_WIDTH-1:0]                      read_data
);

   // R0 is forced here as well so the port stays correct even if the
   // storage for slot 0 were ever shared or repurposed.
   always_comb begin
      read_data = regs[read_addr];
      if (read_addr == ADDR_WIDTH'(REG_ZERO)) begin
         read_data = '0;
      end
   end

endmodule : regfile_read_mux

// File: rtl/register_file.sv
// Two-read, one-write register file with a hardwired-zero R0, asynchronous
// clear and combinational (unbypassed) read ports.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_write_en,
   input  logic [ADDR_WIDTH-1:0] reg_write_dest,
   input  logic [DATA_WIDTH-1:0] reg_write_data,
   input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
   output logic [DATA_WIDTH-1:0] reg_read_data_1,
   input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
   output logic [DATA_WIDTH-1:0] reg_read_data_2
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
   logic                             write_hit;

   // Writes to the zero register are dropped so slot 0 never leaves reset.
   assign write_hit = reg_write_en && (reg_write_dest != ADDR_WIDTH'(REG_ZERO));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else if (write_hit) begin
         regs[reg_write_dest] <= reg_write_data;
      end
   end

   regfile_read_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_read_mux_1 (
      .regs      (regs),
      .read_addr (reg_read_addr_1),
      .read_data (reg_read_data_1)
   );

   regfile_read_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_read_mux_2 (
      .regs      (regs),
      .read_addr (reg_read_addr_2),
      .read_data (reg_read_data_2)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed and randomized self-checking bench for register_file, compared
// against an array-based reference model of the architectural registers.
module tb_register_file;

   logic       clk = 1'b0;
   logic       rst;
   logic       reg_write_en;
   logic [3:0] reg_write_dest;
   logic [7:0] reg_write_data;
   logic [3:0] reg_read_addr_1;
   logic [7:0] reg_read_data_1;
   logic [3:0] reg_read_addr_2;
   logic [7:0] reg_read_data_2;

   int total  = 0;
   int passed = 0;

   // Reference: plain array of architectural values; model[0] is never written.
   logic [7:0] model [16];

   always #5 clk = ~clk;

   register_file dut (
      .clk             (clk),
      .rst             (rst),
      .reg_write_en    (reg_write_en),
      .reg_write_dest  (reg_write_dest),
      .reg_write_data  (reg_write_data),
      .reg_read_addr_1 (reg_read_addr_1),
      .reg_read_data_1 (reg_read_data_1),
      .reg_read_addr_2 (reg_read_addr_2),
      .reg_read_data_2 (reg_read_data_2)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
   endtask

   task automatic model_write(input logic [3:0] dest, input logic [7:0] data);
      if (dest != 4'd0) model[dest] = data;
   endtask

   // Single write cycle: drive at the falling edge, commit at the rising edge.
   task automatic write_reg(input logic [3:0] dest, input logic [7:0] data);
      @(negedge clk);
      reg_write_en   = 1'b1;
      reg_write_dest = dest;
      reg_write_data = data;
      @(posedge clk);
      model_write(dest, data);
      #1;
      reg_write_en = 1'b0;
   endtask

   initial begin
      logic       r_we;
      logic [3:0] r_dest;
      logic [7:0] r_data;

      rst             = 1'b1;
      reg_write_en    = 1'b0;
      reg_write_dest  = 4'd0;
      reg_write_data  = 8'h00;
      reg_read_addr_1 = 4'd0;
      reg_read_addr_2 = 4'd0;
      model_clear();

      #12 rst = 1'b0;
      #1 check("reset_state_p1", reg_read_data_1, 8'h00);

      // Mid-cycle reset pulse, then sweep port 1.
      @(negedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      model_clear();
      for (int i = 0; i < 16; i++) begin
         reg_read_addr_1 = 4'(i);
         #1 check($sformatf("reset_sweep_a%0d", i), reg_read_data_1, model[i]);
      end

      // Write A5 to R3: old value before the edge, new value after it.
      @(negedge clk);
      reg_write_en    = 1'b1;
      reg_write_dest  = 4'd3;
      reg_write_data  = 8'hA5;
      reg_read_addr_1 = 4'd3;
      reg_read_addr_2 = 4'd3;
      #1;
      check("r3_before_edge_p1", reg_read_data_1, 8'h00);
      check("r3_before_edge_p2", reg_read_data_2, 8'h00);
      @(posedge clk);
      model_write(4'd3, 8'hA5);
      #1;
      reg_write_en = 1'b0;
      check("r3_after_edge_p1", reg_read_data_1, 8'hA5);
      check("r3_after_edge_p2", reg_read_data_2, 8'hA5);

      // R0 ignores writes.
      write_reg(4'd0, 8'hFF);
      reg_read_addr_1 = 4'd0;
      reg_read_addr_2 = 4'd0;
      #1;
      check("r0_write_p1", reg_read_data_1, 8'h00);
      check("r0_write_p2", reg_read_data_2, 8'h00);

      // Disabled write must not land.
      @(negedge clk);
      reg_write_en    = 1'b0;
      reg_write_dest  = 4'd5;
      reg_write_data  = 8'h3C;
      reg_read_addr_1 = 4'd5;
      @(posedge clk);
      #1 check("we0_r5", reg_read_data_1, 8'h00);

      // Fill R1..R15 with addr*0x11 and sweep both ports in opposite directions.
      for (int i = 1; i < 16; i++) write_reg(4'(i), 8'(i * 8'h11));
      for (int i = 0; i < 16; i++) begin
         reg_read_addr_1 = 4'(i);
         reg_read_addr_2 = 4'(15 - i);
         #1;
         check($sformatf("fill_p1_a%0d", i), reg_read_data_1, 8'(i * 8'h11));
         check($sformatf("fill_p2_a%0d", 15 - i), reg_read_data_2, 8'((15 - i) * 8'h11));
      end

      // Asynchronous reset between edges clears outputs before the next edge.
      @(negedge clk);
      reg_read_addr_1 = 4'd7;
      reg_read_addr_2 = 4'd12;
      #1;
      check("pre_async_p1", reg_read_data_1, 8'h77);
      check("pre_async_p2", reg_read_data_2, 8'hCC);
      rst = 1'b1;
      #1;
      check("async_rst_p1", reg_read_data_1, 8'h00);
      check("async_rst_p2", reg_read_data_2, 8'h00);
      model_clear();

      // Write coinciding with reset is lost.
      reg_write_en   = 1'b1;
      reg_write_dest = 4'd7;
      reg_write_data = 8'h5A;
      @(posedge clk);
      #1;
      reg_write_en = 1'b0;
      check("rst_priority", reg_read_data_1, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // First write after reset release takes effect on the next edge.
      write_reg(4'd7, 8'h5A);
      #1 check("post_rst_write", reg_read_data_1, 8'h5A);

      // Randomized traffic: reads checked before each edge (no bypass).
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         r_we   = 1'($urandom_range(0, 1));
         r_dest = 4'($urandom_range(0, 15));
         r_data = 8'($urandom);
         reg_write_en    = r_we;
         reg_write_dest  = r_dest;
         reg_write_data  = r_data;
         reg_read_addr_1 = 4'($urandom_range(0, 15));
         reg_read_addr_2 = (n % 7 == 0) ? reg_read_addr_1 : 4'($urandom_range(0, 15));
         #1;
         check("rand_p1", reg_read_data_1, model[reg_read_addr_1]);
         check("rand_p2", reg_read_data_2, model[reg_read_addr_2]);
         @(posedge clk);
         if (r_we) model_write(r_dest, r_data);
      end
      @(negedge clk);
      reg_write_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         reg_read_addr_1 = 4'(i);
         reg_read_addr_2 = 4'(i);
         #1;
         check("final_p1", reg_read_data_1, model[i]);
         check("final_p2", reg_read_data_2, model[i]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_register_file
